// File: rtl/rename_stage.sv
// rename_stage
// Register-rename pipeline stage sitting between decode and dispatch.
// Takes a group of up to RENAME_WIDTH decoded instructions. Each lane that
// writes a non-x0 destination is given a physical register, using the free ID
// the RAT offers for that same lane. Source mappings and previous-destination
// mappings are read from the RAT, with bypass from earlier lanes of the same
// group. The new mappings are committed to the RAT in the cycle the group is
// accepted. The renamed group is then held in one output register until
// dispatch takes it.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   decode_rename_*               incoming decoded group (valid, rd, rd_valid, rs1, rs2)
//   rename_decode_ready           group accepted this cycle (combinational)
//   rat_rename_new_phy_id[_valid] free physical IDs offered, one slot per lane
//   rename_rat_phy_id/_valid/arch_id, rename_rat_map
//                                 new mappings committed in the accept cycle
//   rename_rat_read_arch_id       RAT lookup: port 0 = rs1, port 1 = rs2, port 2 = rd
//   rat_rename_read_phy_id        combinational RAT lookup result (pre-group state)
//   rename_dispatch_*             registered renamed group
//   dispatch_rename_ready         dispatch consumes the output register
//   commit_rename_flush           pipeline flush
module rename_stage #(
  parameter int RENAME_WIDTH      = 4,
  parameter int ARCH_REG_NUM      = 32,
  parameter int PHY_REG_NUM       = 64,
  parameter int ARCH_REG_ID_WIDTH = $clog2(ARCH_REG_NUM),
  parameter int PHY_REG_ID_WIDTH  = $clog2(PHY_REG_NUM)
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [RENAME_WIDTH-1:0]                           decode_rename_valid,
  input  logic [RENAME_WIDTH-1:0][ARCH_REG_ID_WIDTH-1:0]    decode_rename_rd,
  input  logic [RENAME_WIDTH-1:0]                           decode_rename_rd_valid,
  input  logic [RENAME_WIDTH-1:0][ARCH_REG_ID_WIDTH-1:0]    decode_rename_rs1,
  input  logic [RENAME_WIDTH-1:0][ARCH_REG_ID_WIDTH-1:0]    decode_rename_rs2,
  output logic                                              rename_decode_ready,
  input  logic [RENAME_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]     rat_rename_new_phy_id,
  input  logic [RENAME_WIDTH-1:0]                           rat_rename_new_phy_id_valid,
  output logic [RENAME_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]     rename_rat_phy_id,
  output logic [RENAME_WIDTH-1:0]                           rename_rat_phy_id_valid,
  output logic [RENAME_WIDTH-1:0][ARCH_REG_ID_WIDTH-1:0]    rename_rat_arch_id,
  output logic                                              rename_rat_map,
  output logic [RENAME_WIDTH-1:0][2:0][ARCH_REG_ID_WIDTH-1:0] rename_rat_read_arch_id,
  input  logic [RENAME_WIDTH-1:0][2:0][PHY_REG_ID_WIDTH-1:0]  rat_rename_read_phy_id,
  output logic [RENAME_WIDTH-1:0]                           rename_dispatch_valid,
  output logic [RENAME_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]     rename_dispatch_prs1,
  output logic [RENAME_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]     rename_dispatch_prs2,
  output logic [RENAME_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]     rename_dispatch_prd,
  output logic [RENAME_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]     rename_dispatch_old_prd,
  output logic [RENAME_WIDTH-1:0]                           rename_dispatch_prd_valid,
  input  logic                                              dispatch_rename_ready,
  input  logic                                              commit_rename_flush
);

  localparam int RW = RENAME_WIDTH;
  localparam int PW = PHY_REG_ID_WIDTH;

  typedef logic [RW-1:0][PW-1:0] phy_vec_t;

  logic [RW-1:0] need;
  logic          alloc_ok;
  logic          out_free;
  logic          fire;

  phy_vec_t lane_prs1, lane_prs2, lane_prd, lane_old_prd;

  logic [RW-1:0] valid_q, valid_d;
  logic [RW-1:0] prd_valid_q, prd_valid_d;
  phy_vec_t      prs1_q, prs1_d, prs2_q, prs2_d, prd_q, prd_d, old_prd_q, old_prd_d;

  // Lane i only ever uses offer slot i, so a missing offer for any lane that
  // needs one stalls the whole group.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    alloc_ok = 1'b1;
    need     = '0;
    for (int i = 0; i < RW; i++) begin
      need[i] = decode_rename_valid[i] & decode_rename_rd_valid[i] &
                (decode_rename_rd[i] != '0);
      if (need[i] && !rat_rename_new_phy_id_valid[i]) alloc_ok = 1'b0;
    end
  end

  assign out_free            = ~(|valid_q) | dispatch_rename_ready;
  assign rename_decode_ready = ~rst & ~commit_rename_flush & out_free & alloc_ok;
  assign fire                = rename_decode_ready & (|decode_rename_valid);

  // RAT write side: the ID fields simply follow decode; only map and the
  // per-lane enables qualify them.
  assign rename_rat_map          = fire;
  assign rename_rat_phy_id_valid = fire ? need : '0;
  assign rename_rat_phy_id       = rat_rename_new_phy_id;
  assign rename_rat_arch_id      = decode_rename_rd;

  always_comb begin
    rename_rat_read_arch_id = '0;
    for (int i = 0; i < RW; i++) begin
      rename_rat_read_arch_id[i][0] = decode_rename_rs1[i];
      rename_rat_read_arch_id[i][1] = decode_rename_rs2[i];
      rename_rat_read_arch_id[i][2] = decode_rename_rd[i];
    end
  end

  // Intra-group bypass. The RAT still holds the pre-group mapping, so an
  // earlier lane of this group that writes the same arch register overrides
  // it. Scanning oldest to youngest lets the youngest earlier writer win.
  always_comb begin
    lane_prs1    = '0;
    lane_prs2    = '0;
    lane_prd     = '0;
    lane_old_prd = '0;
    for (int j = 0; j < RW; j++) begin
      lane_prs1[j]    = rat_rename_read_phy_id[j][0];
      lane_prs2[j]    = rat_rename_read_phy_id[j][1];
      lane_old_prd[j] = rat_rename_read_phy_id[j][2];
      for (int i = 0; i < j; i++) begin
        if (need[i] && decode_rename_rd[i] == decode_rename_rs1[j])
          lane_prs1[j] = rat_rename_new_phy_id[i];
        if (need[i] && decode_rename_rd[i] == decode_rename_rs2[j])
          lane_prs2[j] = rat_rename_new_phy_id[i];
        if (need[i] && decode_rename_rd[i] == decode_rename_rd[j])
          lane_old_prd[j] = rat_rename_new_phy_id[i];
      end
      // x0 always reads as physical register 0.
      if (decode_rename_rs1[j] == '0) lane_prs1[j] = '0;
      if (decode_rename_rs2[j] == '0) lane_prs2[j] = '0;
      if (!need[j])                   lane_old_prd[j] = '0;
      lane_prd[j] = need[j] ? rat_rename_new_phy_id[j] : '0;
    end
  end

  // Output register next state. Flush wins over load and hold; fire already
  // excludes flush, but the explicit order keeps the priority obvious.
  always_comb begin
    valid_d     = valid_q;
    prd_valid_d = prd_valid_q;
    prs1_d      = prs1_q;
    prs2_d      = prs2_q;
    prd_d       = prd_q;
    old_prd_d   = old_prd_q;
    if (commit_rename_flush) begin
      valid_d     = '0;
      prd_valid_d = '0;
    end else if (fire) begin
      valid_d     = decode_rename_valid;
      prd_valid_d = need;
      prs1_d      = lane_prs1;
      prs2_d      = lane_prs2;
      prd_d       = lane_prd;
      old_prd_d   = lane_old_prd;
    end else if (dispatch_rename_ready) begin
      valid_d     = '0;
      prd_valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of process ordering.
    if (rst) begin
      valid_q     <= '0;
      prd_valid_q <= '0;
      prs1_q      <= '0;
      prs2_q      <= '0;
      prd_q       <= '0;
      old_prd_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      prd_valid_q <= prd_valid_d;
      prs1_q      <= prs1_d;
      prs2_q      <= prs2_d;
      prd_q       <= prd_d;
      old_prd_q   <= old_prd_d;
    end
  end

  assign rename_dispatch_valid     = valid_q;
  assign rename_dispatch_prd_valid = prd_valid_q;
  assign rename_dispatch_prs1      = prs1_q;
  assign rename_dispatch_prs2      = prs2_q;
  assign rename_dispatch_prd       = prd_q;
  assign rename_dispatch_old_prd   = old_prd_q;

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename pipeline stage between the decode-to-rename interface and dispatch.
- Accepts a group of up to RENAME_WIDTH decoded instructions and, for each destination, allocates a physical register from the free IDs the RAT offers.
- Reads source and previous-destination mappings from the RAT, with intra-group bypass, and commits the new mappings to the RAT in the acceptance cycle.
- Holds the renamed group in a single output register until dispatch accepts it.

Parameters:
RENAME_WIDTH, 4, lanes per group
ARCH_REG_NUM, 32, architectural registers; x0 is hard-wired and never renamed
PHY_REG_NUM, 64, physical registers
ARCH_REG_ID_WIDTH, $clog2(ARCH_REG_NUM), arch id width
PHY_REG_ID_WIDTH, $clog2(PHY_REG_NUM), phy id width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
decode_rename_valid  in  RENAME_WIDTH  per-lane instruction valid
decode_rename_rd  in  RW x ARCH_REG_ID_WIDTH  destination arch id
decode_rename_rd_valid  in  RENAME_WIDTH  lane writes rd
decode_rename_rs1/rs2  in  RW x ARCH_REG_ID_WIDTH  source arch ids
rename_decode_ready  out  1  group accepted this cycle when high
rat_rename_new_phy_id  in  RW x PHY_REG_ID_WIDTH  free phy id offered for lane i
rat_rename_new_phy_id_valid  in  RENAME_WIDTH  offer valid
rename_rat_phy_id  out  RW x PHY_REG_ID_WIDTH  phy id to map
rename_rat_phy_id_valid  out  RENAME_WIDTH  per-lane map enable
rename_rat_arch_id  out  RW x ARCH_REG_ID_WIDTH  arch id to map
rename_rat_map  out  1  commit mappings this cycle
rename_rat_read_arch_id  out  RW x 3 x ARCH_REG_ID_WIDTH  ports 0/1 = rs1/rs2, port 2 = rd
rat_rename_read_phy_id  in  RW x 3 x PHY_REG_ID_WIDTH  combinational lookup result
rename_dispatch_valid  out  RENAME_WIDTH  per-lane output valid
rename_dispatch_prs1/prs2/prd/old_prd  out  RW x PHY_REG_ID_WIDTH  renamed ids
rename_dispatch_prd_valid  out  RENAME_WIDTH  lane allocated prd
dispatch_rename_ready  in  1  dispatch consumes the output register
commit_rename_flush  in  1  pipeline flush

Behaviour:
- Lane i needs allocation (need[i]) iff decode_rename_valid[i] & rd_valid[i] & rd[i] != 0.
- alloc_ok = AND over lanes of (!need[i] | new_phy_id_valid[i]). Lane i always uses offer slot i; lanes are not compacted.
- out_free = !(|rename_dispatch_valid) | dispatch_rename_ready.
- rename_decode_ready = !rst & !flush & out_free & alloc_ok. This is combinational.
- fire = rename_decode_ready & |decode_rename_valid.
- On fire, the same cycle, combinationally:
  - rename_rat_map = 1.
  - rename_rat_phy_id_valid = need.
  - phy_id[i] = new_phy_id[i]; arch_id[i] = rd[i].
  - Otherwise map = 0 and phy_id_valid = 0.
- rename_rat_read_arch_id is driven directly from decode every cycle; the RAT read is combinational. Lookups return the pre-group state.
- Source bypass: for lane j and source s:
  - s == 0 → phy 0.
  - Otherwise, the youngest lane i < j with need[i] & rd[i] == s supplies new_phy_id[i].
  - Otherwise the RAT read result is used.
- old_prd: same rule applied to rd[j] against earlier lanes. If no earlier lane matches, RAT port 2 is used. old_prd = 0 when !need[j].
- prd = new_phy_id[j] if need[j], else 0.
- Output register: on fire, loads all lanes with valid = decode_rename_valid. Else if dispatch_rename_ready, valid clears to 0. Otherwise it holds, with all fields stable.
- Flush: valid clears next cycle. No RAT map is issued that cycle; ready is 0. Flush has priority over fire and over hold.
- Reset (rst high at posedge): all output valid/prd_valid = 0, all id fields = 0. ready and map read 0 while rst is high. Reset mid-hold discards the held group.
- Latency: 1 cycle from fire to rename_dispatch_valid. Throughput: 1 group per cycle when dispatch is ready.

Test Plan:
1. Reset, then a single group: lane0 rd=1, rs1=2, offer new_phy_id[0]=32 → map=1, phy_id_valid=4'b0001, arch_id[0]=1. Next cycle valid=4'b0001, prd=32, prs1=RAT(2), old_prd=RAT(1).
2. Intra-group bypass: lane0 rd=5 (new 33), lane1 rd=5 (new 34) with rs1=5, lane2 rs2=5 → lane1 prs1=33, lane1 old_prd=33, lane2 prs2=34.
3. Allocation stall: lane2 needs rd but new_phy_id_valid=4'b1011 → ready=0, map=0, output unchanged. Raising bit 2 → fire the same cycle.
4. Backpressure: hold dispatch_rename_ready=0 for 3 cycles → outputs stable, ready=0, no map. Then assert ready with a new group present → new group loads in the next cycle.
5. x0 and no-rd lanes: rd=0 with rd_valid=1, rs1=0 → need=0, prd_valid=0, prd=0, prs1=0, and that lane's phy_id_valid bit = 0.
6. Flush while a group is held and a new group is present → no map, valid=0 next cycle. rst asserted mid-hold → all outputs 0 next cycle.
